systolic_feeder: RTL and testbench

- Upstream feeder for the KxK systolic MAC array.
- Accepts one data matrix and one weight matrix per job through a valid/ready handshake, then drives a weight-load phase.
- Streams the data matrix into the array's row inputs with diagonal skew (lane r delayed r cycles), then drains while partial sums propagate, and signals completion.
- Removes all skew and sequencing logic from the array top.

---
 rtl/systolic_feeder_if.sv | 28 ++
 rtl/systolic_feeder.sv | 123 ++++++++++++
 tb/tb_systolic_feeder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// Job/array-side bundle for systolic_feeder: job offer handshake in, weight
// strobe and skewed per-lane row stream out.
interface systolic_feeder_if #(
  parameter int K  = 2,
  parameter int DW = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [K*K*DW-1:0]   in_data;
  logic [K*K*DW-1:0]   in_weights;
  logic                stall;
  logic                load_weights;
  logic [K*K*DW-1:0]   weights_out;
  logic [K-1:0]        row_valid;
  logic [K*DW-1:0]     row_data;
  logic                busy;
  logic                done;

  modport master (
    output in_valid, in_data, in_weights, stall,
    input  in_ready, load_weights, weights_out, row_valid, row_data, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_weights, stall,
    output in_ready, load_weights, weights_out, row_valid, row_data, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Feeder for a KxK systolic MAC array: captures A/W, strobes the weight load,
// streams A with lane r delayed r cycles, drains, then pulses done.
module systolic_feeder #(
  parameter int K         = 2,
  parameter int DW        = 8,
  parameter int WLOAD_CYC = 1,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  systolic_feeder_if.slave bus
);
  localparam int CW = $clog2(2*K + WLOAD_CYC + DRAIN_CYC) + 1;
  localparam int MW = K*K*DW;
  localparam logic [CW-1:0] WLOAD_LAST  = CW'(WLOAD_CYC - 1);
  localparam logic [CW-1:0] STREAM_LAST = CW'(2*K - 2);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   a_q, a_d, w_q, w_d;
  logic            idle_q, idle_d;
  logic            load_q, load_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [K-1:0]    rv_q, rv_d;
  logic [K*DW-1:0] rd_q, rd_d;
  logic            accept;

  // idle_q is a flop so in_ready stays low throughout reset.
  assign bus.in_ready = idle_q & ~bus.stall;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    w_d     = w_q;
    if (!bus.stall) begin
      unique case (state_q)
        IDLE: if (accept) begin
          a_d     = bus.in_data;
          w_d     = bus.in_weights;
          cnt_d   = '0;
          state_d = LOAD_W;
        end
        LOAD_W: if (cnt_q == WLOAD_LAST) begin
          cnt_d   = '0;
          state_d = STREAM;
        end else cnt_d = cnt_q + 1'b1;
        STREAM: if (cnt_q == STREAM_LAST) begin
          cnt_d   = '0;
          state_d = (DRAIN_CYC == 0) ? IDLE : DRAIN;
        end else cnt_d = cnt_q + 1'b1;
        DRAIN: if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else cnt_d = cnt_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered copies of the decode of the next state, so a stall
  // (next == current) naturally holds every output.
  always_comb begin : decode
    int t;
    t      = int'(cnt_d);
    idle_d = (state_d == IDLE);
    load_d = (state_d == LOAD_W);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DRAIN && cnt_d == DRAIN_LAST) ||
             (DRAIN_CYC == 0 && state_d == STREAM && cnt_d == STREAM_LAST);
    rv_d   = '0;
    rd_d   = '0;
    if (state_d == STREAM) begin
      for (int r = 0; r < K; r++) begin
        if (t >= r && t <= r + K - 1) begin
          rv_d[r]            = 1'b1;
          rd_d[r*DW +: DW]   = a_q[((t - r)*K + r)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: captured A/W are plain registers, so they clear on reset like all other state.
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      w_q     <= '0;
      idle_q  <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= '0;
      rd_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      w_q     <= w_d;
      idle_q  <= idle_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.load_weights = load_q;
  assign bus.weights_out  = w_q;
  assign bus.row_valid    = rv_q;
  assign bus.row_data     = rd_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: K=2 (WLOAD 1, DRAIN 2) and
// K=3 (WLOAD 2, DRAIN 0) instances with a per-instance beat scoreboard.
module tb_systolic_feeder;
  typedef struct {
    logic [7:0]  v;
    logic [63:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_feeder_if #(.K(2), .DW(8)) f0 ();
  systolic_feeder_if #(.K(3), .DW(8)) f1 ();

  systolic_feeder #(.K(2), .DW(8), .WLOAD_CYC(1), .DRAIN_CYC(2)) dut0 (
    .clk(clk), .rst(rst), .bus(f0.slave));
  systolic_feeder #(.K(3), .DW(8), .WLOAD_CYC(2), .DRAIN_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .bus(f1.slave));

  beat_t q0[$];
  beat_t q1[$];
  beat_t b0, b1;
  int    hs0 = 0, hs1 = 0, hs_cyc0 = 0, hs_cyc1 = 0, done0 = 0, done1 = 0;
  int    lat0_exp = 6;
  logic  stall_prev0 = 1'b0;
  logic [1:0]  prev_v0 = '0;
  logic [15:0] prev_d0 = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected skewed beats for one job: beat t has lane r = A[t-r][r] when active.
  task automatic push_job(input int which, input int k, input logic [511:0] a);
    beat_t b;
    for (int t = 0; t <= 2*k - 2; t++) begin
      b.v = '0;
      b.d = '0;
      for (int r = 0; r < k; r++) begin
        if (t >= r && t - r < k) begin
          b.v[r]       = 1'b1;
          b.d[r*8 +: 8] = a[((t - r)*k + r)*8 +: 8];
        end
      end
      if (which == 0) q0.push_back(b);
      else            q1.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      q0.delete();
      stall_prev0 = 1'b0;
      prev_v0     = '0;
      prev_d0     = '0;
    end else begin
      if (stall_prev0) begin
        check("k2_hold_valid", f0.row_valid, prev_v0);
        check("k2_hold_data", f0.row_data, prev_d0);
      end else begin
        if (f0.row_valid != 0) begin
          if (q0.size() == 0) check("k2_unexpected_beat", f0.row_valid, 0);
          else begin
            b0 = q0.pop_front();
            check("k2_beat_valid", f0.row_valid, b0.v[1:0]);
            check("k2_beat_data", f0.row_data, b0.d[15:0]);
          end
        end
        if (f0.done) begin
          done0++;
          check("k2_latency", cyc - hs_cyc0, lat0_exp);
          check("k2_beats_left", q0.size(), 0);
        end
      end
      if (f0.in_valid && f0.in_ready) begin
        hs0++;
        hs_cyc0 = cyc;
        push_job(0, 2, 512'(f0.in_data));
      end
      stall_prev0 = f0.stall;
      prev_v0     = f0.row_valid;
      prev_d0     = f0.row_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) q1.delete();
    else begin
      if (f1.row_valid != 0) begin
        if (q1.size() == 0) check("k3_unexpected_beat", f1.row_valid, 0);
        else begin
          b1 = q1.pop_front();
          check("k3_beat_valid", f1.row_valid, b1.v[2:0]);
          check("k3_beat_data", f1.row_data, b1.d[23:0]);
        end
      end
      if (f1.done) begin
        done1++;
        check("k3_latency", cyc - hs_cyc1, 7);
        check("k3_beats_left", q1.size(), 0);
      end
      if (f1.in_valid && f1.in_ready) begin
        hs1++;
        hs_cyc1 = cyc;
        push_job(1, 3, 512'(f1.in_data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done0(input int budget);
    int n = 0;
    while (!f0.done && n < budget) begin
      step();
      n++;
    end
    check("k2_wait_done", f0.done, 1'b1);
  endtask

  localparam logic [31:0] A1 = 32'h0403_0201;
  localparam logic [31:0] A2 = 32'h0c0b_0a09;
  localparam logic [31:0] W1 = 32'h0807_0605;

  logic [71:0] a3, w3;

  initial begin
    f0.in_valid = 1'b0; f0.in_data = '0; f0.in_weights = '0; f0.stall = 1'b0;
    f1.in_valid = 1'b0; f1.in_data = '0; f1.in_weights = '0; f1.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", f0.in_ready, 1'b0);
    check("rst_outputs", {f0.load_weights, f0.row_valid, f0.row_data, f0.busy, f0.done}, '0);
    check("rst_weights", f0.weights_out, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    step();
    check("post_rst_ready", f0.in_ready, 1'b1);

    // Job 1, with job 2 offered back-to-back (cycle numbers relative to handshake).
    f0.in_valid = 1'b1; f0.in_data = A1; f0.in_weights = W1;
    step();                                              // cycle 1
    f0.in_data = A2;
    check("c1_load", f0.load_weights, 1'b1);
    check("c1_weights", f0.weights_out, W1);
    check("c1_ready", f0.in_ready, 1'b0);
    step();                                              // cycle 2
    check("c2_rows", {f0.row_valid, f0.row_data}, {2'b01, 16'h0001});
    step();                                              // cycle 3
    check("c3_rows", {f0.row_valid, f0.row_data}, {2'b11, 16'h0203});
    step();                                              // cycle 4
    check("c4_rows", {f0.row_valid, f0.row_data}, {2'b10, 16'h0400});
    step();                                              // cycle 5
    check("c5_rows_done", {f0.row_valid, f0.done}, 3'b000);
    step();                                              // cycle 6
    check("c6_done", {f0.row_valid, f0.done}, 3'b001);
    step();                                              // cycle 7
    check("c7_ready", f0.in_ready, 1'b1);
    check("c7_done_low", f0.done, 1'b0);
    check("c7_weights_kept", f0.weights_out, W1);
    step();                                              // cycle 8
    f0.in_valid = 1'b0;
    check("b2b_handshakes", hs0, 2);
    step();                                              // cycle 9
    check("b2b_lane0", f0.row_data[7:0], 8'd9);
    wait_done0(10);
    step();
    check("b2b_done_count", done0, 2);

    // Stall for 3 cycles from cycle 3.
    lat0_exp = 9;
    f0.in_valid = 1'b1; f0.in_data = A1;
    step(); f0.in_valid = 1'b0;                          // cycle 1
    step(); step();                                      // cycle 3
    check("st_c3", {f0.row_valid, f0.row_data}, {2'b11, 16'h0203});
    f0.stall = 1'b1;
    check("st_ready_low", f0.in_ready, 1'b0);
    step();
    check("st_c4", {f0.row_valid, f0.row_data}, {2'b11, 16'h0203});
    step();
    check("st_c5", {f0.row_valid, f0.row_data}, {2'b11, 16'h0203});
    step();                                              // cycle 6
    f0.stall = 1'b0;
    check("st_c6", {f0.row_valid, f0.row_data}, {2'b11, 16'h0203});
    step();
    check("st_c7", {f0.row_valid, f0.row_data}, {2'b10, 16'h0400});
    wait_done0(10);
    step();

    // Offers and data changes while busy must be ignored.
    lat0_exp = 6;
    f0.in_valid = 1'b1; f0.in_data = A1;
    for (int i = 1; i <= 5; i++) begin
      step();
      f0.in_valid = i[0];
      f0.in_data  = $urandom;
      check("busy_ready_low", f0.in_ready, 1'b0);
    end
    step();                                              // cycle 6
    f0.in_valid = 1'b0;
    check("busy_done", f0.done, 1'b1);
    check("busy_handshakes", hs0, 4);
    step();

    // Asynchronous reset in the first DRAIN cycle.
    f0.in_valid = 1'b1; f0.in_data = A2;
    step(); f0.in_valid = 1'b0;
    repeat (4) step();                                   // cycle 5
    check("pre_rst_busy", f0.busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_outputs", {f0.in_ready, f0.load_weights, f0.row_valid, f0.row_data,
                           f0.busy, f0.done}, '0);
    check("arst_weights", f0.weights_out, '0);
    @(negedge clk);
    #2 rst = 1'b1;
    step();
    check("arst_ready", f0.in_ready, 1'b1);
    f0.in_valid = 1'b1; f0.in_data = A1;
    step(); f0.in_valid = 1'b0;
    wait_done0(10);
    step();
    check("k2_done_count", done0, 5);
    check("k2_hs_count", hs0, 6);

    // K=3, WLOAD_CYC=2, DRAIN_CYC=0.
    for (int n = 0; n < 9; n++) begin
      a3[n*8 +: 8] = 8'(n + 1);
      w3[n*8 +: 8] = 8'(8'h10 + n);
    end
    f1.in_valid = 1'b1; f1.in_data = a3; f1.in_weights = w3;
    step(); f1.in_valid = 1'b0;                          // cycle 1
    check("k3_c1_load", f1.load_weights, 1'b1);
    check("k3_c1_weights", f1.weights_out, w3);
    step();
    check("k3_c2_load", f1.load_weights, 1'b1);
    step();
    check("k3_c3_rows", f1.row_valid, 3'b001);
    step(); step();                                      // cycle 5
    check("k3_c5_valid", f1.row_valid, 3'b111);
    check("k3_c5_lane2", f1.row_data[23:16], 8'd3);
    step(); step();                                      // cycle 7
    check("k3_c7_valid", f1.row_valid, 3'b100);
    check("k3_c7_lane2", f1.row_data[23:16], 8'd9);
    check("k3_c7_done", f1.done, 1'b1);
    step();
    check("k3_c8_idle", {f1.done, f1.in_ready, f1.busy}, 3'b010);
    check("k3_done_count", done1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
